// File: rtl/adder_seq_nbit_if.sv
// Purpose : operand/result bundle for the chunk-serial adder.
// Latency : n/a (wires only).
// Backpr. : none; start is accepted only while the adder is idle.
// Ports   : start, a, b, carry_in (master -> slave);
//           busy, done, sum, overflow (slave -> master).
interface adder_seq_nbit_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 carry_in;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] sum;
  logic                 overflow;

  // Requester side: drives operands and start, observes status/result.
  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  // Adder side.
  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );
endinterface

// File: rtl/adder_seq_nbit.sv
// Purpose : unsigned BIT_WIDTH adder evaluated CHUNK_WIDTH bits per clock.
// Latency : NUM_CHUNKS busy cycles after start is accepted, then a 1-cycle done pulse.
// Backpr. : start is ignored while busy or done; requester must wait for idle.
// Ports   : clk, rst (async, active-high);
//           io_bus.slave : start/a/b/carry_in in, busy/done/sum/overflow out.
module adder_seq_nbit #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  adder_seq_nbit_if.slave io_bus
);

  localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
  // A single-chunk configuration still needs a 1-bit index to stay legal.
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if ((BIT_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
      $error("BIT_WIDTH must be an integer multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BIT_WIDTH-1:0]   r_a;
  logic [BIT_WIDTH-1:0]   r_b;
  logic [BIT_WIDTH-1:0]   r_sum;
  logic                   r_carry;
  logic                   r_ovf;
  logic [IDX_W-1:0]       r_idx;

  logic [31:0]            w_bit_base;
  logic [CHUNK_WIDTH-1:0] w_a_chunk;
  logic [CHUNK_WIDTH-1:0] w_b_chunk;
  logic [CHUNK_WIDTH:0]   w_chunk_sum;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_busy;
  logic                   w_done;

  // Chunk datapath: one CHUNK_WIDTH-bit add with carry per ADD cycle.
  assign w_bit_base  = 32'(r_idx) * 32'(CHUNK_WIDTH);
  assign w_a_chunk   = r_a[w_bit_base +: CHUNK_WIDTH];
  assign w_b_chunk   = r_b[w_bit_base +: CHUNK_WIDTH];
  assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                     + {{CHUNK_WIDTH{1'b0}}, r_carry};
  assign w_last      = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_state_nxt = S_ADD;
          w_accept    = 1'b1;
        end
      end
      S_ADD: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and chunk-by-chunk result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // Operands are frozen here so later input changes cannot leak in.
      r_a     <= io_bus.a;
      r_b     <= io_bus.b;
      r_carry <= io_bus.carry_in;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == S_ADD) begin
      r_sum[w_bit_base +: CHUNK_WIDTH] <= w_chunk_sum[CHUNK_WIDTH-1:0];
      r_carry                          <= w_chunk_sum[CHUNK_WIDTH];
      if (w_last) begin
        // Index parks on the last chunk instead of wrapping.
        r_ovf <= w_chunk_sum[CHUNK_WIDTH];
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign io_bus.busy     = w_busy;
  assign io_bus.done     = w_done;
  assign io_bus.sum      = r_sum;
  assign io_bus.overflow = r_ovf;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Purpose : directed checks of the chunk-serial adder (16/4 and 8/8 builds).
// Latency : n/a.
// Backpr. : n/a.
module tb_adder_seq_nbit;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  adder_seq_nbit_if #(.BIT_WIDTH(16)) bus16();
  adder_seq_nbit_if #(.BIT_WIDTH(8))  bus8();

  adder_seq_nbit #(.BIT_WIDTH(16), .CHUNK_WIDTH(4)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus16)
  );

  adder_seq_nbit #(.BIT_WIDTH(8), .CHUNK_WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one 16-bit addition from the current (idle) negedge and checks
  // the busy window, done pulse, result and hold. With disturb set, start and
  // new operands are thrown at the adder while it is busy.
  task automatic run_op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum, input logic exp_ovf,
                          input bit disturb);
    int n_busy;
    int n_both;
    bus16.a        = a;
    bus16.b        = b;
    bus16.carry_in = cin;
    bus16.start    = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    check_val({tag, " sum cleared"}, 32'(bus16.sum), 32'h0);
    n_busy = 0;
    n_both = 0;
    while (bus16.busy && n_busy < 20) begin
      if (bus16.done) n_both++;
      if (disturb && n_busy == 0) begin
        bus16.start    = 1'b1;
        bus16.a        = 16'h0001;
        bus16.b        = 16'h0001;
        bus16.carry_in = 1'b1;
      end
      n_busy++;
      @(negedge clk);
    end
    bus16.start = 1'b0;
    check_val({tag, " busy cycles"}, 32'(n_busy), 32'd4);
    check_val({tag, " busy&done"}, 32'(n_both), 32'd0);
    check_val({tag, " done"}, 32'(bus16.done), 32'd1);
    check_val({tag, " sum"}, 32'(bus16.sum), 32'(exp_sum));
    check_val({tag, " overflow"}, 32'(bus16.overflow), 32'(exp_ovf));
    @(negedge clk);
    check_val({tag, " done pulse ends"}, 32'(bus16.done), 32'd0);
    check_val({tag, " idle after done"}, 32'(bus16.busy), 32'd0);
    check_val({tag, " sum held"}, 32'(bus16.sum), 32'(exp_sum));
    check_val({tag, " overflow held"}, 32'(bus16.overflow), 32'(exp_ovf));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus16.start    = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    bus16.carry_in = 1'b0;
    bus8.start     = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.carry_in  = 1'b0;

    // Reset state.
    #2;
    check_val("rst busy", 32'(bus16.busy), 32'd0);
    check_val("rst done", 32'(bus16.done), 32'd0);
    check_val("rst sum", 32'(bus16.sum), 32'h0);
    check_val("rst overflow", 32'(bus16.overflow), 32'd0);
    check_val("rst busy8", 32'(bus8.busy), 32'd0);
    check_val("rst done8", 32'(bus8.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, then a back-to-back start in the idle cycle after done.
    run_op16("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op16("b2b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Carry ripples through every chunk.
    run_op16("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Restart and operand changes while busy must be ignored.
    run_op16("ignore", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Abort after two ADD cycles; partial sum visible before reset.
    bus16.a        = 16'h0F0F;
    bus16.b        = 16'h0101;
    bus16.carry_in = 1'b0;
    bus16.start    = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    check_val("abort add0 sum", 32'(bus16.sum), 32'h0000);
    @(negedge clk);
    check_val("abort add1 sum", 32'(bus16.sum), 32'h0000);
    @(negedge clk);
    check_val("abort add2 sum", 32'(bus16.sum), 32'h0010);
    check_val("abort add2 busy", 32'(bus16.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_val("abort busy", 32'(bus16.busy), 32'd0);
    check_val("abort done", 32'(bus16.done), 32'd0);
    check_val("abort sum", 32'(bus16.sum), 32'h0);
    @(negedge clk);
    check_val("abort no done", 32'(bus16.done), 32'd0);
    rst = 1'b0;
    run_op16("restart", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Single-chunk build: one ADD cycle then done.
    bus8.a        = 8'hFF;
    bus8.b        = 8'h01;
    bus8.carry_in = 1'b0;
    bus8.start    = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check_val("w8 busy", 32'(bus8.busy), 32'd1);
    check_val("w8 no done yet", 32'(bus8.done), 32'd0);
    @(negedge clk);
    check_val("w8 busy ends", 32'(bus8.busy), 32'd0);
    check_val("w8 done", 32'(bus8.done), 32'd1);
    check_val("w8 sum", 32'(bus8.sum), 32'h00);
    check_val("w8 overflow", 32'(bus8.overflow), 32'd1);
    @(negedge clk);
    check_val("w8 done pulse ends", 32'(bus8.done), 32'd0);
    check_val("w8 overflow held", 32'(bus8.overflow), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
